adder_array: RTL and testbench



---
 rtl/adder_array.sv | 118 +++++++++++
 tb/tb_adder_array.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_array.sv
// adder_array: four independent WIDTH-bit lane adders with a command-selected
// lane enable and registered sums / per-lane overflow flags (1-cycle latency).
// Optional build macro: ADDER_ARRAY_SIGNED_OVF_EN -- when defined, the lane
// flag reports two's-complement signed overflow instead of unsigned carry-out.

// One lane: WIDTH-bit adder producing the wrapped sum and the lane flag.
module adder_array_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             flag_o
);

  logic             carry;
  logic [WIDTH-1:0] sum;

  // Full-width add; the extra bit is the unsigned carry-out.
  assign {carry, sum} = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o        = sum;

`ifdef ADDER_ARRAY_SIGNED_OVF_EN
  // Signed overflow: operands agree in sign but the result sign differs.
  assign flag_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
`else
  assign flag_o = carry;
`endif

endmodule

// Top level: enable decode plus output registers around four lane adders.
module adder_array #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] ain0,
  input  logic [WIDTH-1:0] ain1,
  input  logic [WIDTH-1:0] ain2,
  input  logic [WIDTH-1:0] ain3,
  input  logic [WIDTH-1:0] bin0,
  input  logic [WIDTH-1:0] bin1,
  input  logic [WIDTH-1:0] bin2,
  input  logic [WIDTH-1:0] bin3,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [3:0]       overflow
);

  logic [WIDTH-1:0] ain_w  [4];
  logic [WIDTH-1:0] bin_w  [4];
  logic [WIDTH-1:0] sum_w  [4];
  logic [3:0]       flag_w;
  logic [3:0]       en_w;

  logic [WIDTH-1:0] dout_d [4];
  logic [WIDTH-1:0] dout_q [4];
  logic [3:0]       ovf_d;
  logic [3:0]       ovf_q;

  assign ain_w[0] = ain0;
  assign ain_w[1] = ain1;
  assign ain_w[2] = ain2;
  assign ain_w[3] = ain3;
  assign bin_w[0] = bin0;
  assign bin_w[1] = bin1;
  assign bin_w[2] = bin2;
  assign bin_w[3] = bin3;

  // Lanes are fully independent: no carry passes between them.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      adder_array_lane #(.WIDTH(WIDTH)) u_lane (
        .a_i    (ain_w[gi]),
        .b_i    (bin_w[gi]),
        .sum_o  (sum_w[gi]),
        .flag_o (flag_w[gi])
      );
      // Lane gi is live for its own command code and for the broadcast code 4.
      assign en_w[gi] = (cmd == 3'(gi)) || (cmd == 3'd4);
    end
  endgenerate

  // Next-state: disabled lanes load zero rather than holding their value.
  always_comb begin
    ovf_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      dout_d[i] = '0;
      if (en_w[i]) begin
        dout_d[i] = sum_w[i];
        ovf_d[i]  = flag_w[i];
      end
    end
  end

  // Output registers, cleared immediately by reset independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dout_q[i] <= '0;
      ovf_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) dout_q[i] <= dout_d[i];
      ovf_q <= ovf_d;
    end
  end

  assign dout0    = dout_q[0];
  assign dout1    = dout_q[1];
  assign dout2    = dout_q[2];
  assign dout3    = dout_q[3];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_array.sv
// Testbench for adder_array: table-driven vectors and random command cycling,
// with expected results queued at drive time and popped one edge later.
module tb_adder_array;

  logic        clk;
  logic        rst;
  logic [2:0]  cmd;
  logic [31:0] ain0, ain1, ain2, ain3;
  logic [31:0] bin0, bin1, bin2, bin3;
  logic [31:0] dout0, dout1, dout2, dout3;
  logic [3:0]  overflow;

  int checks;
  int errors;

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0]       o;
  } exp_t;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    exp_t             e;
  } vec_t;

  exp_t sb_q[$];

  adder_array #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .ain0(ain0), .ain1(ain1), .ain2(ain2), .ain3(ain3),
    .bin0(bin0), .bin1(bin1), .bin2(bin2), .bin3(bin3),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Compare all outputs against one expected record.
  task automatic check_all(input string tag, input exp_t e);
    check($sformatf("%s dout0", tag), dout0, e.d[0]);
    check($sformatf("%s dout1", tag), dout1, e.d[1]);
    check($sformatf("%s dout2", tag), dout2, e.d[2]);
    check($sformatf("%s dout3", tag), dout3, e.d[3]);
    check($sformatf("%s overflow", tag), {28'd0, overflow}, {28'd0, e.o});
    $display("%s: cmd=%0d dout=%08h %08h %08h %08h ovf=%04b", tag, cmd,
             dout0, dout1, dout2, dout3, overflow);
  endtask

  // Independent reference model of one operation.
  function automatic exp_t model(input logic [2:0] c, input logic [3:0][31:0] a,
                                 input logic [3:0][31:0] b);
    exp_t  r;
    logic [32:0] s;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      if (c == 3'(n) || c == 3'd4) begin
        s = {1'b0, a[n]} + {1'b0, b[n]};
        r.d[n] = s[31:0];
`ifdef ADDER_ARRAY_SIGNED_OVF_EN
        r.o[n] = (a[n][31] == b[n][31]) && (s[31] != a[n][31]);
`else
        r.o[n] = s[32];
`endif
      end
    end
    return r;
  endfunction

  task automatic set_inputs(input logic [2:0] c, input logic [3:0][31:0] a,
                            input logic [3:0][31:0] b);
    cmd = c;
    ain0 = a[0]; ain1 = a[1]; ain2 = a[2]; ain3 = a[3];
    bin0 = b[0]; bin1 = b[1]; bin2 = b[2]; bin3 = b[3];
  endtask

  // Drive one operation, queue its expectation, and check it after the edge.
  task automatic drive(input string tag, input logic [2:0] c, input logic [3:0][31:0] a,
                       input logic [3:0][31:0] b, input exp_t e);
    exp_t got_e;
    @(negedge clk);
    set_inputs(c, a, b);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue required one entry", tag);
    end else begin
      got_e = sb_q.pop_front();
      check_all(tag, got_e);
    end
  endtask

  vec_t vecs[4];
  exp_t zero_e;

  initial begin
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [2:0]       c;
    checks = 0;
    errors = 0;
    zero_e = '0;
    rst = 1'b1;
    set_inputs(3'd0, '0, '0);

    // Table: lane-2 select, broadcast corners, wrap on lane 0, idle code 7.
    vecs[0].cmd = 3'd2;
    vecs[0].a = {32'h1111_1111, 32'h0000_0005, 32'h1111_1111, 32'h1111_1111};
    vecs[0].b = {32'h1111_1111, 32'h0000_0007, 32'h1111_1111, 32'h1111_1111};
    vecs[0].e.d = {32'h0, 32'h0000_000C, 32'h0, 32'h0};
    vecs[0].e.o = 4'b0000;

    vecs[1].cmd = 3'd4;
    vecs[1].a = {32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};
    vecs[1].b = {32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
    vecs[1].e.d = {32'h0, 32'h0, 32'h8000_0000, 32'h0000_0003};
`ifdef ADDER_ARRAY_SIGNED_OVF_EN
    vecs[1].e.o = 4'b1010;
`else
    vecs[1].e.o = 4'b1100;
`endif

    vecs[2].cmd = 3'd0;
    vecs[2].a = {32'h5, 32'h6, 32'h7, 32'hFFFF_FFFF};
    vecs[2].b = {32'h5, 32'h6, 32'h7, 32'h0000_0001};
    vecs[2].e.d = {32'h0, 32'h0, 32'h0, 32'h0};
`ifdef ADDER_ARRAY_SIGNED_OVF_EN
    vecs[2].e.o = 4'b0000;
`else
    vecs[2].e.o = 4'b0001;
`endif

    vecs[3].cmd = 3'd7;
    vecs[3].a = {32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3].b = {32'hCAFE_F00D, 32'h8765_4321, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3].e = '0;

    // Reset state while held.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold", zero_e);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      drive($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].e);

    // Load nonzero outputs, then assert reset mid-cycle: outputs clear at once.
    drive("preload", vecs[1].cmd, vecs[1].a, vecs[1].b, vecs[1].e);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_reset", zero_e);
    // The in-flight operation is discarded while reset spans an edge.
    set_inputs(vecs[1].cmd, vecs[1].a, vecs[1].b);
    @(posedge clk);
    #1;
    check_all("reset_edge", zero_e);
    @(negedge clk);
    rst = 1'b0;
    // First edge after release loads normally.
    drive("post_reset", vecs[0].cmd, vecs[0].a, vecs[0].b, vecs[0].e);

    // Idle code 6 with random operands.
    for (int n = 0; n < 4; n++) begin
      a[n] = $urandom;
      b[n] = $urandom;
    end
    drive("cmd6", 3'd6, a, b, zero_e);

    // Cycle 0..4 with operands below 2^31.
    for (int i = 0; i < 32; i++) begin
      c = 3'(i % 5);
      for (int n = 0; n < 4; n++) begin
        a[n] = $urandom & 32'h7FFF_FFFF;
        b[n] = $urandom & 32'h7FFF_FFFF;
      end
      drive($sformatf("cyc%0d", i), c, a, b, model(c, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion required finish before 100000");
    $fatal(1);
  end

endmodule
